// File: rtl/i2c_regbank_pkg.sv
// i2c_regbank_pkg
// Shared definitions for the I2C APB register bank: register byte offsets,
// STATUS bit positions, packed register layouts and a slave-address helper.
// Optional feature macro used by the bank: I2C_REGBANK_IRQ_EN.
package i2c_regbank_pkg;

    localparam logic [7:0] OFF_ADDR   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_MASK   = 8'h08;
    localparam logic [7:0] OFF_TXDATA = 8'h0C;
    localparam logic [7:0] OFF_RXDATA = 8'h10;
    localparam logic [7:0] OFF_LEVEL  = 8'h14;

    localparam int ST_NAK     = 0;
    localparam int ST_TRA     = 1;
    localparam int ST_REC     = 2;
    localparam int ST_RXOVF   = 3;
    localparam int ST_TXEMPTY = 8;
    localparam int ST_TXFULL  = 9;
    localparam int ST_RXEMPTY = 10;
    localparam int ST_RXFULL  = 11;

    typedef struct packed {
        logic        tba;
        logic [20:0] rsvd;
        logic [9:0]  slvaddr;
    } addr_reg_t;

    // w1c holds {RXOVF, REC, TRA, NAK}
    typedef struct packed {
        logic [19:0] rsvd_hi;
        logic        rxfull;
        logic        rxempty;
        logic        txfull;
        logic        txempty;
        logic [3:0]  rsvd_lo;
        logic [3:0]  w1c;
    } status_reg_t;

    typedef struct packed {
        logic [27:0] rsvd;
        logic [3:0]  mask;
    } mask_reg_t;

    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] rxlvl;
        logic [7:0] rsvd_lo;
        logic [7:0] txlvl;
    } level_reg_t;

    // In 7-bit mode the upper three address bits are forced to zero.
    function automatic logic [9:0] clip_slvaddr(input logic tba, input logic [9:0] sa);
        clip_slvaddr = tba ? sa : {3'b000, sa[6:0]};
    endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// i2c_byte_fifo
// Byte FIFO with DEPTH entries (power of two). A push while full is accepted
// only when a pop happens in the same cycle; a pop while empty is ignored.
// Ports: clk, rst (async active-high, empties the FIFO at once), push, pop,
// wdata[7:0], rdata[7:0] (head, 0 when empty), full, empty, level[LVL_W-1:0].
module i2c_byte_fifo import i2c_regbank_pkg::*; #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against occupancy; a simultaneous pop frees a full slot.
    always_comb begin
        empty     = (level_r == {LVL_W{1'b0}});
        full      = (level_r == LVL_W'(DEPTH));
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        level     = level_r;
        rdata     = empty ? 8'h00 : mem_r[rd_ptr_r];
    end

    // Storage array; contents are only observable through rdata when non-empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1'b1);
                2'b01:   level_r <= level_r - LVL_W'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/i2c_apb_regbank_fifo.sv
// i2c_apb_regbank_fifo
// APB register bank for the I2C controller with TX/RX byte FIFOs, 7/10-bit
// slave addressing, sticky W1C status and PSLVERR on illegal accesses.
// Optional feature: define I2C_REGBANK_IRQ_EN to implement MASK and o_irq;
// otherwise MASK reads 0 (writes ignored) and o_irq is tied low.
// Ports: HCLK, HRESET (async active-high); APB slave i_PADDR/i_PWDATA/
// i_PWRITE/i_PSEL/i_PENABLE -> o_PRDATA/o_PREADY/o_PSLVERR; controller side
// o_tba, o_slvaddr, o_tx_byte/o_tx_valid/i_tx_ready, i_rx_byte/i_rx_valid,
// event strobes i_tra/i_nak, and registered interrupt o_irq.
module i2c_apb_regbank_fifo import i2c_regbank_pkg::*; #(
    parameter  int APB_ADDR_WIDTH = 12,
    parameter  int APB_DATA_WIDTH = 32,
    parameter  int FIFO_DEPTH     = 8,
    localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] i_PADDR,
    input  logic [APB_DATA_WIDTH-1:0] i_PWDATA,
    input  logic                      i_PWRITE,
    input  logic                      i_PSEL,
    input  logic                      i_PENABLE,
    output logic [APB_DATA_WIDTH-1:0] o_PRDATA,
    output logic                      o_PREADY,
    output logic                      o_PSLVERR,
    output logic                      o_tba,
    output logic [9:0]                o_slvaddr,
    output logic [7:0]                o_tx_byte,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    input  logic [7:0]                i_rx_byte,
    input  logic                      i_rx_valid,
    input  logic                      i_tra,
    input  logic                      i_nak,
    output logic                      o_irq
);

    logic             access_s, err_s, wr_ok_s, rd_ok_s;
    logic [7:0]       offset_s;
    logic [31:0]      rdata_s;
    addr_reg_t        addr_r;
    logic [3:0]       w1c_r, w1c_set_s, w1c_clr_s, mask_s;
    status_reg_t      status_view_s;
    mask_reg_t        mask_view_s;
    level_reg_t       level_view_s;
    logic             tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic             rx_pop_s, rx_full_s, rx_empty_s, rx_acc_s, rx_drop_s;
    logic [7:0]       rx_head_s;
    logic [LVL_W-1:0] tx_level_s, rx_level_s;
    logic             unused_s;

    assign unused_s = ^i_PWDATA[30:10];
    assign o_PREADY = 1'b1;

    // APB decode: error classification and read-data selection.
    always_comb begin
        access_s = i_PSEL & i_PENABLE;
        offset_s = i_PADDR[7:0];
        err_s    = 1'b0;
        rdata_s  = 32'h0000_0000;
        if (i_PADDR[APB_ADDR_WIDTH-1:8] != {(APB_ADDR_WIDTH-8){1'b0}}) begin
            err_s = 1'b1;
        end else begin
            case (offset_s)
                OFF_ADDR:   rdata_s = addr_r;
                OFF_STATUS: rdata_s = status_view_s;
                OFF_MASK:   rdata_s = mask_view_s;
                OFF_TXDATA: err_s = ~i_PWRITE | tx_full_s;
                OFF_RXDATA: begin
                    err_s   = i_PWRITE | rx_empty_s;
                    rdata_s = {24'h00_0000, rx_head_s};
                end
                OFF_LEVEL: begin
                    err_s   = i_PWRITE;
                    rdata_s = level_view_s;
                end
                default: err_s = 1'b1;
            endcase
        end
        wr_ok_s   = access_s & i_PWRITE & ~err_s;
        rd_ok_s   = access_s & ~i_PWRITE & ~err_s;
        o_PSLVERR = access_s & err_s;
        if (rd_ok_s) begin
            o_PRDATA = rdata_s;
        end else begin
            o_PRDATA = 32'h0000_0000;
        end
    end

    // FIFO handshakes and status event sources.
    always_comb begin
        tx_push_s  = wr_ok_s & (offset_s == OFF_TXDATA);
        tx_pop_s   = ~tx_empty_s & i_tx_ready;
        o_tx_valid = ~tx_empty_s;
        rx_pop_s   = rd_ok_s & (offset_s == OFF_RXDATA);
        // A full RX FIFO still accepts the push if the bus pops this cycle.
        rx_acc_s   = i_rx_valid & (~rx_full_s | rx_pop_s);
        rx_drop_s  = i_rx_valid & ~rx_acc_s;
        w1c_set_s  = 4'h0;
        w1c_set_s[ST_RXOVF] = rx_drop_s;
        w1c_set_s[ST_REC]   = rx_acc_s;
        w1c_set_s[ST_TRA]   = i_tra;
        w1c_set_s[ST_NAK]   = i_nak;
        if (wr_ok_s && (offset_s == OFF_STATUS)) begin
            w1c_clr_s = i_PWDATA[3:0];
        end else begin
            w1c_clr_s = 4'h0;
        end
    end

    // Read views of STATUS, MASK and LEVEL.
    always_comb begin
        status_view_s         = status_reg_t'(32'h0000_0000);
        status_view_s.w1c     = w1c_r;
        status_view_s.txempty = tx_empty_s;
        status_view_s.txfull  = tx_full_s;
        status_view_s.rxempty = rx_empty_s;
        status_view_s.rxfull  = rx_full_s;
        mask_view_s           = mask_reg_t'(32'h0000_0000);
        mask_view_s.mask      = mask_s;
        level_view_s          = level_reg_t'(32'h0000_0000);
        level_view_s.txlvl    = 8'(tx_level_s);
        level_view_s.rxlvl    = 8'(rx_level_s);
    end

    // ADDR register and sticky status; a hardware set beats a same-cycle clear.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_r <= addr_reg_t'(32'h0000_0000);
            w1c_r  <= 4'h0;
        end else begin
            if (wr_ok_s && (offset_s == OFF_ADDR)) begin
                addr_r.tba     <= i_PWDATA[31];
                addr_r.rsvd    <= 21'h00_0000;
                addr_r.slvaddr <= clip_slvaddr(i_PWDATA[31], i_PWDATA[9:0]);
            end
            w1c_r <= (w1c_r & ~w1c_clr_s) | w1c_set_s;
        end
    end

    assign o_tba     = addr_r.tba;
    assign o_slvaddr = addr_r.slvaddr;

`ifdef I2C_REGBANK_IRQ_EN
    logic [3:0] mask_r;
    logic       irq_r;

    // Interrupt mask and registered interrupt request.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mask_r <= 4'h0;
            irq_r  <= 1'b0;
        end else begin
            if (wr_ok_s && (offset_s == OFF_MASK)) begin
                mask_r <= i_PWDATA[3:0];
            end
            irq_r <= |(w1c_r & mask_r);
        end
    end

    assign mask_s = mask_r;
    assign o_irq  = irq_r;
`else
    assign mask_s = 4'h0;
    assign o_irq  = 1'b0;
`endif

    i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .wdata (i_PWDATA[7:0]),
        .rdata (o_tx_byte),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .level (tx_level_s)
    );

    i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (i_rx_valid),
        .pop   (rx_pop_s),
        .wdata (i_rx_byte),
        .rdata (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .level (rx_level_s)
    );

endmodule

// File: tb/tb_i2c_apb_regbank_fifo.sv
// tb_i2c_apb_regbank_fifo
// Directed and randomized stimulus for i2c_apb_regbank_fifo. Expected APB
// responses and controller-side outputs are predicted by a queue-based model
// and pushed to scoreboards; a negedge monitor pops and compares them.
// Honours I2C_REGBANK_IRQ_EN the same way as the design.
module tb_i2c_apb_regbank_fifo;

    localparam int D = 8;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        tba;
    logic [9:0]  slvaddr;
    logic [7:0]  tx_byte;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid, tra, nak, irq;

    always #5 HCLK = ~HCLK;

    i2c_apb_regbank_fifo #(.APB_ADDR_WIDTH(12), .APB_DATA_WIDTH(32), .FIFO_DEPTH(D)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .i_PADDR(PADDR), .i_PWDATA(PWDATA), .i_PWRITE(PWRITE), .i_PSEL(PSEL), .i_PENABLE(PENABLE),
        .o_PRDATA(PRDATA), .o_PREADY(PREADY), .o_PSLVERR(PSLVERR),
        .o_tba(tba), .o_slvaddr(slvaddr), .o_tx_byte(tx_byte), .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
        .i_tra(tra), .i_nak(nak), .o_irq(irq)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [11:0] addr;
    } apb_exp_t;

    typedef struct {
        logic       tv;
        logic [7:0] tb;
        logic       irq;
        logic       tba;
        logic [9:0] sa;
    } sb_exp_t;

    apb_exp_t apb_q[$];
    sb_exp_t  sb_q[$];

    // Reference model state
    logic [7:0] tx_m[$];
    logic [7:0] rx_m[$];
    logic [3:0] st_m, mask_m;
    logic       irq_m, tba_m;
    logic [9:0] sa_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        tx_m.delete();
        rx_m.delete();
        st_m = 4'h0; mask_m = 4'h0; irq_m = 1'b0; tba_m = 1'b0; sa_m = 10'h000;
    endtask

    // Monitor: compares DUT outputs against scoreboard entries.
    always @(negedge HCLK) begin
        sb_exp_t  e;
        apb_exp_t a;
        if (!HRESET) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("tx_valid", {31'h0, tx_valid}, {31'h0, e.tv});
                chk("tx_byte", {24'h0, tx_byte}, {24'h0, e.tb});
                chk("irq", {31'h0, irq}, {31'h0, e.irq});
                chk("tba", {31'h0, tba}, {31'h0, e.tba});
                chk("slvaddr", {22'h0, slvaddr}, {22'h0, e.sa});
                chk("pready", {31'h0, PREADY}, 32'h1);
            end
            if (PSEL && PENABLE) begin
                if (apb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL apb_unexpected at %0t: access with no expectation", $time);
                end else begin
                    a = apb_q.pop_front();
                    chk($sformatf("prdata@%03h", a.addr), PRDATA, a.rdata);
                    chk($sformatf("pslverr@%03h", a.addr), {31'h0, PSLVERR}, {31'h0, a.err});
                end
            end
        end
    end

    // One clock of stimulus: predict outputs from the model, then advance it.
    task automatic step(input logic sel, input logic en, input logic wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic rxv, input logic [7:0] rxb,
                        input logic tr, input logic nk);
        sb_exp_t s; apb_exp_t x;
        logic err, wok, rok, txpop, txpush, rxpop, rxacc, irq_n;
        logic [31:0] rd; logic [7:0] off, tmp; logic [3:0] clr, setv;
        int txs, rxs;
        PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = a; PWDATA = wd;
        rx_valid = rxv; rx_byte = rxb; tra = tr; nak = nk;
        txs = tx_m.size(); rxs = rx_m.size();
        s.tv = (txs > 0); s.tb = (txs > 0) ? tx_m[0] : 8'h00;
        s.irq = irq_m; s.tba = tba_m; s.sa = sa_m;
        sb_q.push_back(s);
        err = 1'b0; rd = 32'h0; off = a[7:0];
        if (a[11:8] != 4'h0) err = 1'b1;
        else case (off)
            8'h00: rd = {tba_m, 21'h0, sa_m};
            8'h04: rd = {20'h0, rxs == D, rxs == 0, txs == D, txs == 0, 4'h0, st_m};
            8'h08: rd = {28'h0, mask_m};
            8'h0C: err = !wr || (txs == D);
            8'h10: begin err = wr || (rxs == 0); if (!err) rd = {24'h0, rx_m[0]}; end
            8'h14: begin err = wr; rd = {8'h0, 8'(rxs), 8'h0, 8'(txs)}; end
            default: err = 1'b1;
        endcase
        if (err || wr) rd = 32'h0;
        if (sel && en) begin
            x.rdata = rd; x.err = err; x.addr = a;
            apb_q.push_back(x);
        end
        wok = sel && en && wr && !err;
        rok = sel && en && !wr && !err;
        txpop  = tx_ready && (txs > 0);
        txpush = wok && (off == 8'h0C);
        rxpop  = rok && (off == 8'h10);
        rxacc  = rxv && ((rxs < D) || rxpop);
        clr    = (wok && off == 8'h04) ? wd[3:0] : 4'h0;
        setv   = {rxv && !rxacc, rxacc, tr, nk};
        irq_n  = |(st_m & mask_m);
        if (txpop) tmp = tx_m.pop_front();
        if (txpush) tx_m.push_back(wd[7:0]);
        if (rxpop) tmp = rx_m.pop_front();
        if (rxacc) rx_m.push_back(rxb);
        st_m = (st_m & ~clr) | setv;
        if (wok && off == 8'h00) begin
            tba_m = wd[31];
            sa_m  = wd[31] ? wd[9:0] : {3'b000, wd[6:0]};
        end
`ifdef I2C_REGBANK_IRQ_EN
        if (wok && off == 8'h08) mask_m = wd[3:0];
        irq_m = irq_n;
`else
        irq_m = 1'b0;
`endif
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] wd, input logic tr_acc);
        step(1'b1, 1'b0, wr, a, wd, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, wr, a, wd, 1'b0, 8'h00, tr_acc, 1'b0);
    endtask

    task automatic rx_push(input logic [7:0] b);
        step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, b, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] addrs [8];
        logic [11:0] a;
        logic [31:0] wd;
        logic        w;
        addrs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h104};
        HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h000; PWDATA = 32'h0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; tra = 1'b0; nak = 1'b0;
        model_reset();
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Reset state
        apb(1'b0, 12'h004, 32'h0, 1'b0);
        apb(1'b0, 12'h014, 32'h0, 1'b0);
        idle(1);

        // TX fill to full, then overflow attempt
        apb(1'b1, 12'h00C, 32'h0000_00A5, 1'b0);
        apb(1'b1, 12'h00C, 32'h0000_003C, 1'b0);
        for (int i = 0; i < D - 2; i++) apb(1'b1, 12'h00C, $urandom, 1'b0);
        apb(1'b0, 12'h004, 32'h0, 1'b0);
        apb(1'b1, 12'h00C, 32'h0000_0077, 1'b0);
        apb(1'b0, 12'h014, 32'h0, 1'b0);
        tx_ready = 1'b1;
        idle(D + 1);
        tx_ready = 1'b0;

        // RX overflow and drain
        for (int i = 0; i < D + 1; i++) rx_push(8'($urandom));
        apb(1'b0, 12'h004, 32'h0, 1'b0);
        for (int i = 0; i < D; i++) apb(1'b0, 12'h010, 32'h0, 1'b0);
        apb(1'b0, 12'h010, 32'h0, 1'b0);

        // Interrupt and W1C against a simultaneous set
        apb(1'b1, 12'h004, 32'h0000_000F, 1'b0);
        apb(1'b1, 12'h008, 32'h0000_0002, 1'b0);
        step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);
        apb(1'b1, 12'h004, 32'h0000_0002, 1'b1);
        apb(1'b0, 12'h004, 32'h0, 1'b0);
        apb(1'b1, 12'h004, 32'h0000_0002, 1'b0);
        idle(2);
        apb(1'b0, 12'h004, 32'h0, 1'b0);
        apb(1'b0, 12'h008, 32'h0, 1'b0);

        // Addressing and error decode
        apb(1'b1, 12'h000, 32'h8000_03FF, 1'b0);
        apb(1'b0, 12'h000, 32'h0, 1'b0);
        apb(1'b1, 12'h000, 32'h0000_03FF, 1'b0);
        apb(1'b0, 12'h000, 32'h0, 1'b0);
        apb(1'b0, 12'h018, 32'h0, 1'b0);
        apb(1'b1, 12'h018, 32'h0, 1'b0);
        apb(1'b0, 12'h104, 32'h0, 1'b0);
        apb(1'b1, 12'h014, 32'h0, 1'b0);
        apb(1'b1, 12'h010, 32'h0, 1'b0);
        apb(1'b0, 12'h00C, 32'h0, 1'b0);

        // Asynchronous reset with both FIFOs occupied
        for (int i = 0; i < 3; i++) apb(1'b1, 12'h00C, $urandom, 1'b0);
        for (int i = 0; i < 3; i++) rx_push(8'($urandom));
        HRESET = 1'b1;
        #1;
        chk("async_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("async_rst_tx_byte", {24'h0, tx_byte}, 32'h0);
        chk("async_rst_irq", {31'h0, irq}, 32'h0);
        model_reset();
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        apb(1'b0, 12'h014, 32'h0, 1'b0);
        apb(1'b0, 12'h004, 32'h0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 6) begin
                a  = addrs[$urandom_range(0, 7)];
                w  = 1'($urandom_range(0, 1));
                wd = $urandom;
                step(1'b1, 1'b0, w, a, wd, 1'($urandom_range(0, 1)), 8'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
                step(1'b1, 1'b1, w, a, wd, 1'($urandom_range(0, 1)), 8'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            end else begin
                step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'($urandom_range(0, 1)), 8'($urandom),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            end
        end
        tx_ready = 1'b0;
        idle(2);

        checks++;
        if (apb_q.size() != 0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: apb left %0d side left %0d expected 0", apb_q.size(), sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
